// File: rtl/cpu_pkg.sv
// Shared fetch-path types and default sizing used by the fetch queue and its byte ring.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        HALT
    } fetch_state_t;

    localparam int DEF_BEAT_BYTES = 8;
    localparam int DEF_BUF_BYTES  = 128;
    localparam int DEF_HIGH_WATER = 115;
    localparam int DEF_LOW_WATER  = 51;

endpackage

// File: rtl/fetch_byte_ring.sv
// Circular byte store: appends the tail of a memory beat at the write pointer and
// presents a BEAT_BYTES-wide window starting at the read pointer.
module fetch_byte_ring
    import cpu_pkg::*;
#(
    parameter int BEAT_BYTES = DEF_BEAT_BYTES,
    parameter int BUF_BYTES  = DEF_BUF_BYTES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [8*BEAT_BYTES-1:0]       wr_data,
    input  logic [$clog2(BEAT_BYTES)-1:0] wr_off,
    input  logic [$clog2(BEAT_BYTES):0]   rd_count,
    output logic [8*BEAT_BYTES-1:0]       rd_data,
    output logic [$clog2(BUF_BYTES):0]    occupancy
);

    localparam int OFF_W = $clog2(BEAT_BYTES);
    localparam int CNT_W = OFF_W + 1;
    localparam int PTR_W = $clog2(BUF_BYTES);
    localparam int OCC_W = PTR_W + 1;

    logic [7:0]       mem_q [BUF_BYTES];
    logic [7:0]       mem_d [BUF_BYTES];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] wr_count;

    assign wr_count  = CNT_W'(BEAT_BYTES) - CNT_W'(wr_off);
    assign occupancy = occ_q;

    // Byte i of the beat lands at wr_ptr + (i - wr_off); leading bytes below wr_off are dropped.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && !flush) begin
            for (int i = 0; i < BEAT_BYTES; i++) begin
                if (i >= int'(wr_off)) begin
                    mem_d[wr_ptr_q + PTR_W'(i) - PTR_W'(wr_off)] = wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(rd_count);
            wr_ptr_d = wr_en ? (wr_ptr_q + PTR_W'(wr_count)) : wr_ptr_q;
            occ_d    = occ_q - OCC_W'(rd_count) + (wr_en ? OCC_W'(wr_count) : OCC_W'(0));
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            rd_data[8*i +: 8] = mem_q[rd_ptr_q + PTR_W'(i)];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    occ_in_range: assert property (@(posedge clk) disable iff (rst) occ_q <= OCC_W'(BUF_BYTES));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: one-outstanding aligned beat requests feeding a byte ring,
// with watermark hysteresis, redirect flush and fault latching.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter int                BEAT_BYTES = DEF_BEAT_BYTES,
    parameter int                BUF_BYTES  = DEF_BUF_BYTES,
    parameter int                HIGH_WATER = DEF_HIGH_WATER,
    parameter int                LOW_WATER  = DEF_LOW_WATER,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_valid,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [ADDR_W-1:0]             mem_req_addr,
    input  logic                          mem_resp_valid,
    input  logic [8*BEAT_BYTES-1:0]       mem_resp_data,
    input  logic                          mem_resp_fault,
    output logic [8*BEAT_BYTES-1:0]       deq_data,
    output logic [$clog2(BEAT_BYTES):0]   deq_avail,
    input  logic [$clog2(BEAT_BYTES):0]   deq_count,
    output logic [ADDR_W-1:0]             deq_pc,
    output logic [$clog2(BUF_BYTES):0]    occupancy,
    output logic                          fault_valid,
    output logic [ADDR_W-1:0]             fault_pc
);

    localparam int OFF_W = $clog2(BEAT_BYTES);
    localparam int CNT_W = OFF_W + 1;
    localparam int OCC_W = $clog2(BUF_BYTES) + 1;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] deq_pc_q, deq_pc_d;
    logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              fault_valid_q, fault_valid_d;
    logic              req_valid_q, req_valid_d;
    logic              fetch_en_q, fetch_en_d;

    logic [OFF_W-1:0]  beat_off;
    logic [CNT_W-1:0]  deq_take;
    logic              append;
    logic              room;
    logic              req_outstanding;

    assign beat_off  = fetch_pc_q[OFF_W-1:0];
    assign deq_avail = (occupancy >= OCC_W'(BEAT_BYTES)) ? CNT_W'(BEAT_BYTES) : occupancy[CNT_W-1:0];
    assign room      = (int'(occupancy) + BEAT_BYTES) <= BUF_BYTES;
    assign append    = (state_q == WAIT) && mem_resp_valid && !mem_resp_fault && !redirect_valid;

    // A response arriving in the redirect cycle closes the transaction, so nothing is left to drain.
    assign req_outstanding = ((state_q == WAIT)  && !mem_resp_valid) ||
                             ((state_q == REQ)   && mem_req_ready)   ||
                             ((state_q == DRAIN) && !mem_resp_valid);

    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign deq_pc        = deq_pc_q;
    assign fault_valid   = fault_valid_q;
    assign fault_pc      = fault_pc_q;

    always_comb begin
        if (occupancy >= OCC_W'(HIGH_WATER)) begin
            fetch_en_d = 1'b0;
        end else if (occupancy <= OCC_W'(LOW_WATER)) begin
            fetch_en_d = 1'b1;
        end else begin
            fetch_en_d = fetch_en_q;
        end
    end

    always_comb begin
        if (redirect_valid) begin
            deq_take = '0;
        end else if (deq_count > deq_avail) begin
            deq_take = deq_avail;
        end else begin
            deq_take = deq_count;
        end
    end

    fetch_byte_ring #(
        .BEAT_BYTES(BEAT_BYTES),
        .BUF_BYTES (BUF_BYTES)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .wr_en    (append),
        .wr_data  (mem_resp_data),
        .wr_off   (beat_off),
        .rd_count (deq_take),
        .rd_data  (deq_data),
        .occupancy(occupancy)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        deq_pc_d      = deq_pc_q + ADDR_W'(deq_take);
        fault_valid_d = fault_valid_q;
        fault_pc_d    = fault_pc_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;

        case (state_q)
            IDLE: begin
                if (fetch_en_d && room && !fault_valid_q) begin
                    state_d     = REQ;
                    req_valid_d = 1'b1;
                    req_addr_d  = fetch_pc_q & ~ADDR_W'(BEAT_BYTES - 1);
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d     = WAIT;
                    req_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if (mem_resp_fault) begin
                        state_d       = HALT;
                        fault_valid_d = 1'b1;
                        fault_pc_d    = fetch_pc_q;
                    end else begin
                        state_d    = IDLE;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(BEAT_BYTES) - ADDR_W'(beat_off);
                    end
                end
            end
            DRAIN: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect overrides everything, including a response landing this cycle.
        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc;
            deq_pc_d      = redirect_pc;
            fault_valid_d = 1'b0;
            req_valid_d   = 1'b0;
            state_d       = req_outstanding ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            deq_pc_q      <= RESET_PC;
            fault_valid_q <= 1'b0;
            fault_pc_q    <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            fetch_en_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            deq_pc_q      <= deq_pc_d;
            fault_valid_q <= fault_valid_d;
            fault_pc_q    <= fault_pc_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            fetch_en_q    <= fetch_en_d;
        end
    end

    deq_count_legal: assert property (@(posedge clk) disable iff (rst)
        !redirect_valid |-> deq_count <= deq_avail);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a request-address scoreboard checked by a monitor,
// plus hand-computed occupancy, dequeue-window and fault checks.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        mem_resp_fault;
    logic [63:0] deq_data;
    logic [3:0]  deq_avail;
    logic [3:0]  deq_count;
    logic [63:0] deq_pc;
    logic [7:0]  occupancy;
    logic        fault_valid;
    logic [63:0] fault_pc;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_req_q[$];
    logic [63:0] exp_pc;
    int          resp_delay = 0;
    logic [63:0] fault_addr = '1;

    fetch_queue #(
        .ADDR_W    (64),
        .BEAT_BYTES(8),
        .BUF_BYTES (128),
        .HIGH_WATER(115),
        .LOW_WATER (51),
        .RESET_PC  (64'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .mem_resp_fault(mem_resp_fault),
        .deq_data      (deq_data),
        .deq_avail     (deq_avail),
        .deq_count     (deq_count),
        .deq_pc        (deq_pc),
        .occupancy     (occupancy),
        .fault_valid   (fault_valid),
        .fault_pc      (fault_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
    endfunction

    function automatic logic [63:0] beat_at(input logic [63:0] a);
        logic [63:0] b;
        for (int i = 0; i < 8; i++) b[8*i +: 8] = mem_byte(a + 64'(i));
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_range(input logic [63:0] start, input int n);
        for (int i = 0; i < n; i++) exp_req_q.push_back(start + 64'(8 * i));
    endtask

    // One cycle of stimulus; consumed bytes are checked against the memory model first.
    task automatic applyStimulus(input logic redir, input logic [63:0] pc, input int cnt);
        logic [63:0] exp_data;
        logic [63:0] mask;
        if (!redir && cnt > 0) begin
            exp_data = '0;
            mask     = '0;
            for (int i = 0; i < cnt; i++) begin
                exp_data[8*i +: 8] = mem_byte(exp_pc + 64'(i));
                mask[8*i +: 8]     = 8'hFF;
            end
            checkOutput("deq_pc", deq_pc, exp_pc);
            checkOutput("deq_data", deq_data & mask, exp_data);
        end
        redirect_valid = redir;
        redirect_pc    = pc;
        deq_count      = 4'(cnt);
        @(negedge clk);
        redirect_valid = 1'b0;
        deq_count      = '0;
        exp_pc         = redir ? pc : exp_pc + 64'(cnt);
    endtask

    // Memory model: accepts at the edge after a negedge where valid&ready, answers one cycle later.
    initial begin
        logic        pending;
        logic [63:0] pend_addr;
        int          delay;
        pending        = 1'b0;
        pend_addr      = '0;
        delay          = 0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        mem_resp_fault = 1'b0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_fault = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    if (delay == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = beat_at(pend_addr);
                        mem_resp_fault = (pend_addr == fault_addr);
                        pending        = 1'b0;
                    end else begin
                        delay--;
                    end
                end
                if (mem_req_valid && mem_req_ready) begin
                    pending   = 1'b1;
                    pend_addr = mem_req_addr;
                    delay     = resp_delay;
                end
            end
        end
    end

    // Request monitor: every accepted request must match the next expected address.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && mem_req_valid && mem_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_req: got 0x%0h, expected no request", mem_req_addr);
                end else begin
                    checkOutput("req_addr", mem_req_addr, exp_req_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wait_cnt;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_count      = '0;
        mem_req_ready  = 1'b1;
        exp_pc         = '0;
        tick(2);

        checkOutput("rst_req_valid", 64'(mem_req_valid), 64'd0);
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_deq_avail", 64'(deq_avail), 64'd0);
        checkOutput("rst_deq_pc", deq_pc, 64'h0);
        checkOutput("rst_fault_valid", 64'(fault_valid), 64'd0);
        checkOutput("rst_fault_pc", fault_pc, 64'h0);

        // Aligned stream fills to 120 and stops at the high watermark.
        push_range(64'h0, 15);
        rst = 1'b0;
        tick(60);
        checkOutput("fill_occupancy", 64'(occupancy), 64'd120);
        checkOutput("fill_deq_avail", 64'(deq_avail), 64'd8);
        checkOutput("fill_req_valid", 64'(mem_req_valid), 64'd0);
        checkOutput("fill_reqs_done", 64'(exp_req_q.size()), 64'd0);

        // Drain to 56: still above the low watermark, so no request.
        repeat (8) applyStimulus(1'b0, 64'h0, 8);
        checkOutput("drain_occupancy", 64'(occupancy), 64'd56);
        tick(5);
        checkOutput("hold_req_valid", 64'(mem_req_valid), 64'd0);

        // Reaching 51 resumes fetch until 115.
        push_range(64'h78, 8);
        applyStimulus(1'b0, 64'h0, 5);
        tick(40);
        checkOutput("refill_occupancy", 64'(occupancy), 64'd115);
        checkOutput("refill_reqs_done", 64'(exp_req_q.size()), 64'd0);

        // 7 bytes per cycle across the ring boundary.
        repeat (9) applyStimulus(1'b0, 64'h0, 7);
        checkOutput("wrap_occupancy", 64'(occupancy), 64'd52);
        checkOutput("wrap_deq_pc", deq_pc, 64'h84);
        tick(5);
        checkOutput("wrap_req_valid", 64'(mem_req_valid), 64'd0);

        // Unaligned redirect drops the leading three bytes of the first beat.
        push_range(64'h10, 1);
        push_range(64'h18, 14);
        applyStimulus(1'b1, 64'h13, 0);
        tick(3);
        checkOutput("unaligned_occupancy", 64'(occupancy), 64'd5);
        checkOutput("unaligned_deq_avail", 64'(deq_avail), 64'd5);
        checkOutput("unaligned_deq_pc", deq_pc, 64'h13);
        checkOutput("unaligned_byte0", 64'(deq_data[7:0]), 64'(mem_byte(64'h13)));
        tick(50);
        checkOutput("unaligned_fill_occ", 64'(occupancy), 64'd117);
        checkOutput("unaligned_reqs_done", 64'(exp_req_q.size()), 64'd0);

        // Redirect while the 0x40 response is still pending.
        resp_delay = 4;
        push_range(64'h40, 1);
        push_range(64'h100, 15);
        applyStimulus(1'b1, 64'h40, 0);
        tick(2);
        applyStimulus(1'b1, 64'h100, 0);
        resp_delay = 0;
        checkOutput("redir_wait_occupancy", 64'(occupancy), 64'd0);
        checkOutput("redir_wait_req_valid", 64'(mem_req_valid), 64'd0);
        wait_cnt = 0;
        while (occupancy == 8'd0 && wait_cnt < 40) begin
            tick(1);
            wait_cnt++;
        end
        checkOutput("drain_first_occ", 64'(occupancy), 64'd8);
        checkOutput("drain_first_beat", deq_data, beat_at(64'h100));
        checkOutput("drain_first_pc", deq_pc, 64'h100);
        tick(60);
        checkOutput("drain_fill_occ", 64'(occupancy), 64'd120);
        checkOutput("drain_reqs_done", 64'(exp_req_q.size()), 64'd0);

        // Fault latches the unaligned fetch pc and halts fetch.
        fault_addr = 64'h28;
        push_range(64'h28, 1);
        applyStimulus(1'b1, 64'h2C, 0);
        tick(15);
        checkOutput("fault_valid", 64'(fault_valid), 64'd1);
        checkOutput("fault_pc", fault_pc, 64'h2C);
        checkOutput("fault_req_valid", 64'(mem_req_valid), 64'd0);
        checkOutput("fault_occupancy", 64'(occupancy), 64'd0);
        fault_addr = '1;
        push_range(64'h0, 15);
        applyStimulus(1'b1, 64'h0, 0);
        checkOutput("fault_cleared", 64'(fault_valid), 64'd0);
        tick(60);
        checkOutput("resume_occupancy", 64'(occupancy), 64'd120);
        checkOutput("resume_reqs_done", 64'(exp_req_q.size()), 64'd0);

        // Dequeue 3 in the same cycle the 0x10 beat lands at occupancy 10.
        push_range(64'h0, 16);
        applyStimulus(1'b1, 64'h6, 0);
        tick(8);
        checkOutput("simul_pre_occ", 64'(occupancy), 64'd10);
        applyStimulus(1'b0, 64'h0, 3);
        checkOutput("simul_occ", 64'(occupancy), 64'd15);
        checkOutput("simul_deq_pc", deq_pc, 64'h9);
        tick(50);
        checkOutput("simul_fill_occ", 64'(occupancy), 64'd119);
        checkOutput("simul_reqs_done", 64'(exp_req_q.size()), 64'd0);

        // Asynchronous reset in the middle of a pending request.
        resp_delay = 5;
        push_range(64'h200, 1);
        applyStimulus(1'b1, 64'h200, 0);
        tick(2);
        checkOutput("pre_rst_deq_pc", deq_pc, 64'h200);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_req_valid", 64'(mem_req_valid), 64'd0);
        checkOutput("async_rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("async_rst_deq_avail", 64'(deq_avail), 64'd0);
        checkOutput("async_rst_deq_pc", deq_pc, 64'h0);
        checkOutput("async_rst_fault_valid", 64'(fault_valid), 64'd0);
        checkOutput("async_rst_fault_pc", fault_pc, 64'h0);
        resp_delay = 0;
        tick(2);
        push_range(64'h0, 1);
        rst = 1'b0;
        wait_cnt = 0;
        while (exp_req_q.size() != 0 && wait_cnt < 20) begin
            tick(1);
            wait_cnt++;
        end
        checkOutput("post_rst_reqs_done", 64'(exp_req_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
